// File: rtl/y_adder_seq.sv
// Digit-serial adder/subtractor: one D-bit digit per clock, LSB first.
// Registered sum, carry-out and signed overflow with a start/busy/done handshake.
module y_adder_seq #(
    parameter int W = 8,
    parameter int D = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] z,
    output logic         cout,
    output logic         ovf
);

    localparam int N  = (D >= 1) ? (W / D) : 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    generate
        if (D < 1 || (W % D) != 0) begin : g_bad_params
            $error("y_adder_seq: W must be a positive multiple of D");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          carry_q, carry_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  z_q, z_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;

    logic [D:0]    digit;
    logic          last;

    always_comb begin
        digit = {1'b0, a_q[int'(idx_q)*D +: D]}
              + {1'b0, b_q[int'(idx_q)*D +: D]}
              + {{D{1'b0}}, carry_q};
        last  = (idx_q == IW'(N - 1));
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        z_d     = z_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // Subtraction is A + ~B + 1, folded in at load time.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    z_d     = '0;
                    idx_d   = '0;
                    state_d = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                z_d[int'(idx_q)*D +: D] = digit[D-1:0];
                carry_d = digit[D];
                idx_d   = idx_q + IW'(1);
                if (last) begin
                    cout_d  = digit[D];
                    ovf_d   = (a_q[W-1] == b_q[W-1]) &&
                              (z_d[W-1] != a_q[W-1]);
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            z_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            z_q     <= z_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign z    = z_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_y_adder_seq.sv
// Bench for y_adder_seq: four instances (W2/D1, W8/D2, W16/D4, W16/D16)
// checked against an arithmetic reference model and directed vectors.
module tb_y_adder_seq;

    logic clk;
    logic rst;

    logic       st0, sb0, ci0, bu0, dn0, co0, ov0;
    logic [1:0] a0, b0, z0;
    logic       st1, sb1, ci1, bu1, dn1, co1, ov1;
    logic [7:0] a1, b1, z1;
    logic        st2, sb2, ci2, bu2, dn2, co2, ov2;
    logic [15:0] a2, b2, z2;
    logic        st3, sb3, ci3, bu3, dn3, co3, ov3;
    logic [15:0] a3, b3, z3;

    int checks = 0;
    int errors = 0;

    y_adder_seq #(.W(2), .D(1)) u_w2d1 (
        .clk(clk), .rst(rst), .start(st0), .sub(sb0), .a(a0), .b(b0),
        .cin(ci0), .busy(bu0), .done(dn0), .z(z0), .cout(co0), .ovf(ov0));
    y_adder_seq #(.W(8), .D(2)) u_w8d2 (
        .clk(clk), .rst(rst), .start(st1), .sub(sb1), .a(a1), .b(b1),
        .cin(ci1), .busy(bu1), .done(dn1), .z(z1), .cout(co1), .ovf(ov1));
    y_adder_seq #(.W(16), .D(4)) u_w16d4 (
        .clk(clk), .rst(rst), .start(st2), .sub(sb2), .a(a2), .b(b2),
        .cin(ci2), .busy(bu2), .done(dn2), .z(z2), .cout(co2), .ovf(ov2));
    y_adder_seq #(.W(16), .D(16)) u_w16d16 (
        .clk(clk), .rst(rst), .start(st3), .sub(sb3), .a(a3), .b(b3),
        .cin(ci3), .busy(bu3), .done(dn3), .z(z3), .cout(co3), .ovf(ov3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic drive(int sel, logic [15:0] a, logic [15:0] b,
                         bit c, bit s, bit go);
        case (sel)
            0: begin a0 = a[1:0]; b0 = b[1:0]; ci0 = c; sb0 = s; st0 = go; end
            1: begin a1 = a[7:0]; b1 = b[7:0]; ci1 = c; sb1 = s; st1 = go; end
            2: begin a2 = a; b2 = b; ci2 = c; sb2 = s; st2 = go; end
            default: begin a3 = a; b3 = b; ci3 = c; sb3 = s; st3 = go; end
        endcase
    endtask

    task automatic get(int sel, output logic bu, output logic dn,
                       output logic [15:0] zz, output logic co,
                       output logic ov);
        case (sel)
            0: begin bu = bu0; dn = dn0; zz = {14'b0, z0}; co = co0; ov = ov0; end
            1: begin bu = bu1; dn = dn1; zz = {8'b0, z1}; co = co1; ov = ov1; end
            2: begin bu = bu2; dn = dn2; zz = z2; co = co2; ov = ov2; end
            default: begin bu = bu3; dn = dn3; zz = z3; co = co3; ov = ov3; end
        endcase
    endtask

    // Reference: plain integer arithmetic on unsigned and signed values.
    task automatic model(int w, logic [15:0] a, logic [15:0] b, bit c, bit s,
                         output logic [15:0] ez, output logic ec,
                         output logic eo);
        int ua, ub, full, sa, sb, r, lim;
        lim = 1 << w;
        ua = int'(a) % lim;
        ub = int'(b) % lim;
        full = s ? (ua - ub + lim) : (ua + ub + int'(c));
        ez = 16'(full % lim);
        ec = (full >= lim);
        sa = (ua >= lim / 2) ? ua - lim : ua;
        sb = (ub >= lim / 2) ? ub - lim : ub;
        r = s ? (sa - sb) : (sa + sb + int'(c));
        eo = (r > lim / 2 - 1) || (r < -(lim / 2));
    endtask

    // Starts an op at the current negedge and returns at the negedge where
    // done is high (or after a 50-cycle timeout). poke re-asserts start with
    // fresh operands one cycle into RUN.
    task automatic op(int sel, logic [15:0] a, logic [15:0] b, bit c, bit s,
                      bit poke, output logic [15:0] zz, output logic co,
                      output logic ov, output int lat, output int bcnt);
        logic bu, dn;
        drive(sel, a, b, c, s, 1'b1);
        @(negedge clk);
        drive(sel, 16'($urandom), 16'($urandom), 1'($urandom),
              1'($urandom), 1'b0);
        lat  = 0;
        bcnt = 0;
        get(sel, bu, dn, zz, co, ov);
        while (!dn && lat < 50) begin
            if (bu) bcnt++;
            drive(sel, 16'($urandom), 16'($urandom), 1'($urandom),
                  1'($urandom), poke && lat == 1);
            @(negedge clk);
            lat++;
            get(sel, bu, dn, zz, co, ov);
        end
        drive(sel, 16'($urandom), 16'($urandom), 1'($urandom),
              1'($urandom), 1'b0);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        bit         cin;
        bit         sub;
        logic [7:0] z;
        bit         cout;
        bit         ovf;
    } vec_t;

    vec_t tbl[5];

    initial begin
        logic [15:0] zz, ez;
        logic co, ov, ec, eo, bu, dn;
        int lat, bcnt, seen, sel, n;
        time t1, t2;

        tbl[0] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[3] = '{8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0};
        tbl[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};

        rst = 1'b1;
        for (int k = 0; k < 4; k++) drive(k, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            get(k, bu, dn, zz, co, ov);
            chk($sformatf("reset outputs inst%0d", k),
                {12'b0, bu, dn, co, ov, zz}, 32'h0);
        end
        rst = 1'b0;
        @(negedge clk);

        for (int av = 0; av < 4; av++)
            for (int bv = 0; bv < 4; bv++)
                for (int c = 0; c < 2; c++) begin
                    op(0, 16'(av), 16'(bv), 1'(c), 1'b0, 1'b0,
                       zz, co, ov, lat, bcnt);
                    chk($sformatf("w2 sum %0d+%0d+%0d", av, bv, c),
                        {29'b0, co, zz[1:0]}, 32'(av + bv + c));
                    chk("w2 busy cycles", 32'(bcnt), 32'd2);
                end

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            op(1, {8'h0, tbl[i].a}, {8'h0, tbl[i].b}, tbl[i].cin,
               tbl[i].sub, 1'b0, zz, co, ov, lat, bcnt);
            chk($sformatf("w8 vec%0d z", i), {16'b0, zz}, {24'b0, tbl[i].z});
            chk($sformatf("w8 vec%0d cout", i), {31'b0, co},
                {31'b0, tbl[i].cout});
            chk($sformatf("w8 vec%0d ovf", i), {31'b0, ov},
                {31'b0, tbl[i].ovf});
            chk($sformatf("w8 vec%0d latency", i), 32'(lat), 32'd4);
        end

        @(negedge clk);
        op(1, 16'h5A, 16'h3C, 1'b0, 1'b0, 1'b1, zz, co, ov, lat, bcnt);
        chk("start during run z", {16'b0, zz}, 32'h96);
        chk("start during run latency", 32'(lat), 32'd4);
        @(negedge clk);
        get(1, bu, dn, zz, co, ov);
        chk("idle after done", {30'b0, bu, dn}, 32'h0);

        @(negedge clk);
        op(1, 16'hFF, 16'h01, 1'b0, 1'b0, 1'b0, zz, co, ov, lat, bcnt);
        t1 = $time;
        op(1, 16'h10, 16'h20, 1'b0, 1'b1, 1'b0, zz, co, ov, lat, bcnt);
        t2 = $time;
        chk("back-to-back done spacing", 32'((t2 - t1) / 10), 32'd5);
        chk("back-to-back z", {16'b0, zz}, 32'hF0);
        chk("back-to-back cout", {31'b0, co}, 32'h0);

        @(negedge clk);
        drive(1, 16'hFF, 16'h01, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        drive(1, 16'hFF, 16'h01, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        get(1, bu, dn, zz, co, ov);
        chk("abort outputs", {12'b0, bu, dn, co, ov, zz}, 32'h0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            get(1, bu, dn, zz, co, ov);
            if (dn || bu) seen++;
        end
        chk("no done after abort", 32'(seen), 32'd0);

        for (int s = 0; s < 2; s++) begin
            sel = 2 + s;
            n = (s == 0) ? 4 : 1;
            for (int i = 0; i < 200; i++) begin
                logic [15:0] ra, rb;
                bit rc, rs;
                ra = 16'($urandom);
                rb = 16'($urandom);
                rc = 1'($urandom);
                rs = 1'(i % 2);
                if ($urandom_range(0, 1) == 1) @(negedge clk);
                op(sel, ra, rb, rc, rs, 1'b0, zz, co, ov, lat, bcnt);
                model(16, ra, rb, rc, rs, ez, ec, eo);
                chk($sformatf("sweep%0d z %h %h s%0d", sel, ra, rb, rs),
                    {16'b0, zz}, {16'b0, ez});
                chk($sformatf("sweep%0d cout", sel), {31'b0, co}, {31'b0, ec});
                chk($sformatf("sweep%0d ovf", sel), {31'b0, ov}, {31'b0, eo});
                chk($sformatf("sweep%0d latency", sel), 32'(lat), 32'(n));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
